// File: rtl/fe_fifo_packer_pkg.sv
// Shared definitions for the front-end FIFO word format: command encodings,
// bit-field positions, packer FSM states and the event packing helper.
package fe_fifo_packer_pkg;

  localparam int WORD_W = 18;

  // Command encodings, shared with the capture stage and the software decoder
  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_STAT = 2'd1;
  localparam logic [1:0] CMD_TIME = 2'd2;
  localparam logic [1:0] CMD_OVFL = 2'd3;

  // Word bit-field positions
  localparam int CMD_LSB    = 16;
  localparam int TLO_LSB    = 13;
  localparam int STATUS_LSB = 8;
  localparam int DATA_LSB   = 0;
  localparam int PAYLD_LSB  = 0;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_DROP = 2'd1,
    ST_MARK = 2'd2
  } pack_state_e;

  // Build the FIFO word for one capture-stage event
  function automatic logic [WORD_W-1:0] pack_event(input logic [1:0]  cmd,
                                                   input logic [15:0] tstamp,
                                                   input logic [4:0]  status,
                                                   input logic [7:0]  data);
    logic [WORD_W-1:0] w;
    w = '0;
    w[CMD_LSB +: 2] = cmd;
    if (cmd == CMD_TIME) begin
      w[PAYLD_LSB +: 16] = tstamp;
    end else begin
      w[TLO_LSB +: 3]    = tstamp[2:0];
      w[STATUS_LSB +: 5] = status;
      w[DATA_LSB +: 8]   = (cmd == CMD_STAT) ? 8'h00 : data;
    end
    return w;
  endfunction

endpackage

// File: rtl/fe_fifo_packer_skid.sv
// Two-entry FIFO-ordered skid buffer absorbing back-pressure in front of
// the packer output register. Push and pop may coincide; flush empties it.
module fe_skid_buffer
  import fe_fifo_packer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Entry storage
  // NOTE: storage is not reset; an entry is only ever read after a push wrote it, as tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'(DEPTH));

endmodule

// File: rtl/fe_fifo_packer.sv
// Packs capture-stage events into 18-bit front-end FIFO words. A skid buffer
// absorbs FIFO-full; once it overflows, events are dropped and counted until
// the path drains, then one OVFL marker word carries the drop count.
module fe_fifo_packer
  import fe_fifo_packer_pkg::*;
#(
  parameter int pDROP_CTR_WIDTH = 16,
  parameter int pSKID_DEPTH     = 2
) (
  input  logic                       fe_clk,
  input  logic                       reset_n,
  input  logic                       I_arm,
  input  logic                       I_data_wr,
  input  logic [1:0]                 I_command,
  input  logic [15:0]                I_time,
  input  logic [7:0]                 I_data,
  input  logic [4:0]                 I_status,
  input  logic                       I_fifo_full,
  output logic [WORD_W-1:0]          O_fifo_din,
  output logic                       O_fifo_wr,
  output logic                       O_overflow,
  output logic [pDROP_CTR_WIDTH-1:0] O_drop_total
);

  localparam int CW = pDROP_CTR_WIDTH;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  pack_state_e       state_q, state_d;
  logic              arm_q;
  logic              arm_edge;
  logic [CW-1:0]     drop_ctr_q, drop_ctr_d;
  logic [CW-1:0]     drop_total_d;
  logic              overflow_d;
  logic              fifo_wr_d;
  logic [WORD_W-1:0] fifo_din_d;
  logic [WORD_W-1:0] word_in;
  logic              buf_push, buf_pop, buf_flush;
  logic              buf_empty, buf_full;
  logic [WORD_W-1:0] buf_dout;
  logic              drop;

  assign word_in  = pack_event(I_command, I_time, I_status, I_data);
  assign arm_edge = I_arm & ~arm_q;

  fe_skid_buffer #(
    .WIDTH (WORD_W),
    .DEPTH (pSKID_DEPTH)
  ) u_skid (
    .clk   (fe_clk),
    .rst_n (reset_n),
    .flush (buf_flush),
    .push  (buf_push),
    .din   (word_in),
    .pop   (buf_pop),
    .dout  (buf_dout),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // FSM state register
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_PASS;
    else          state_q <= state_d;
  end

  // Next state, buffer control, drop accounting and output-register selection
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    drop_ctr_d   = drop_ctr_q;
    drop_total_d = O_drop_total;
    overflow_d   = O_overflow;
    fifo_wr_d    = 1'b0;
    fifo_din_d   = O_fifo_din;
    buf_push     = 1'b0;
    buf_pop      = 1'b0;
    buf_flush    = 1'b0;
    drop         = 1'b0;

    if (arm_edge) begin
      // Arm discards everything, including an event in this very cycle
      buf_flush    = 1'b1;
      state_d      = ST_PASS;
      drop_ctr_d   = '0;
      drop_total_d = '0;
      overflow_d   = 1'b0;
    end else begin
      buf_pop = !buf_empty && !I_fifo_full;
      if (buf_pop) begin
        fifo_wr_d  = 1'b1;
        fifo_din_d = buf_dout;
      end

      if (I_data_wr) begin
        if (state_q == ST_PASS && (!buf_full || buf_pop)) begin
          if (buf_empty && !I_fifo_full) begin
            fifo_wr_d  = 1'b1;
            fifo_din_d = word_in;
          end else begin
            buf_push = 1'b1;
          end
        end else begin
          drop = 1'b1;
        end
      end

      if (drop) begin
        drop_ctr_d   = sat_inc(drop_ctr_q);
        drop_total_d = sat_inc(O_drop_total);
        overflow_d   = 1'b1;
      end

      case (state_q)
        ST_PASS: if (drop) state_d = ST_DROP;
        ST_DROP: if (buf_empty && !I_fifo_full) state_d = ST_MARK;
        ST_MARK: begin
          // Marker includes a drop from this same cycle; clear after capture
          if (!I_fifo_full) begin
            fifo_wr_d  = 1'b1;
            fifo_din_d = {CMD_OVFL, 16'(drop_ctr_d)};
            drop_ctr_d = '0;
            state_d    = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  // Arm edge detector, counters and sticky overflow flag
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q        <= 1'b0;
      drop_ctr_q   <= '0;
      O_drop_total <= '0;
      O_overflow   <= 1'b0;
    end else begin
      arm_q        <= I_arm;
      drop_ctr_q   <= drop_ctr_d;
      O_drop_total <= drop_total_d;
      O_overflow   <= overflow_d;
    end
  end

  // Output register feeding the front-end FIFO
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      O_fifo_wr  <= 1'b0;
      O_fifo_din <= '0;
    end else begin
      O_fifo_wr  <= fifo_wr_d;
      O_fifo_din <= fifo_din_d;
    end
  end

endmodule

// File: tb/tb_fe_fifo_packer.sv
// Self-checking bench for fe_fifo_packer: a queue-based behavioural model is
// compared against the DUT every cycle, plus hand-computed literal words.
module tb_fe_fifo_packer;

  logic        fe_clk = 1'b0;
  logic        reset_n;
  logic        I_arm;
  logic        I_data_wr;
  logic [1:0]  I_command;
  logic [15:0] I_time;
  logic [7:0]  I_data;
  logic [4:0]  I_status;
  logic        I_fifo_full;
  logic [17:0] O_fifo_din;
  logic        O_fifo_wr;
  logic        O_overflow;
  logic [15:0] O_drop_total;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  fe_fifo_packer dut (
    .fe_clk       (fe_clk),
    .reset_n      (reset_n),
    .I_arm        (I_arm),
    .I_data_wr    (I_data_wr),
    .I_command    (I_command),
    .I_time       (I_time),
    .I_data       (I_data),
    .I_status     (I_status),
    .I_fifo_full  (I_fifo_full),
    .O_fifo_din   (O_fifo_din),
    .O_fifo_wr    (O_fifo_wr),
    .O_overflow   (O_overflow),
    .O_drop_total (O_drop_total)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference word built with plain arithmetic from the format rules
  function automatic logic [17:0] ref_word(input int cmd, input int t, input int st, input int d);
    int v;
    if (cmd == 2) v = 2 * 65536 + (t % 65536);
    else          v = cmd * 65536 + (t % 8) * 8192 + st * 256 + ((cmd == 1) ? 0 : d);
    return 18'(v);
  endfunction

  // ---------------- behavioural model ----------------
  logic [17:0] mq[$];
  int          pend = 0;
  int          total = 0;
  bit          ovf = 1'b0;
  int          mode = 0;      // 0 accepting, 1 dropping, 2 marker owed
  bit          arm_prev = 1'b0;
  bit          exp_wr = 1'b0;
  logic [17:0] exp_din = '0;
  bit          m_edge;
  int          m_mode0;
  bit          m_empty0;

  always @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      pend = 0; total = 0; ovf = 0; mode = 0; arm_prev = 0;
      exp_wr = 0; exp_din = '0;
    end else begin
      m_edge   = I_arm && !arm_prev;
      arm_prev = I_arm;
      exp_wr   = 0;
      if (m_edge) begin
        mq.delete();
        pend = 0; total = 0; ovf = 0; mode = 0;
      end else begin
        m_mode0  = mode;
        m_empty0 = (mq.size() == 0);
        if (!m_empty0 && !I_fifo_full) begin
          exp_din = mq.pop_front();
          exp_wr  = 1;
        end
        if (I_data_wr) begin
          if (m_mode0 == 0 && mq.size() < 2) begin
            if (m_empty0 && !I_fifo_full) begin
              exp_din = ref_word(I_command, I_time, I_status, I_data);
              exp_wr  = 1;
            end else begin
              mq.push_back(ref_word(I_command, I_time, I_status, I_data));
            end
          end else begin
            if (pend < 65535)  pend++;
            if (total < 65535) total++;
            ovf = 1;
            if (m_mode0 == 0) mode = 1;
          end
        end
        if (m_mode0 == 1 && m_empty0 && !I_fifo_full) mode = 2;
        if (m_mode0 == 2 && !I_fifo_full) begin
          exp_din = 18'(3 * 65536 + pend);
          exp_wr  = 1;
          pend    = 0;
          mode    = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge fe_clk) begin
    if (cmp_en) begin
      check("cyc_wr", 32'(O_fifo_wr), 32'(exp_wr));
      if (exp_wr) check("cyc_din", 32'(O_fifo_din), 32'(exp_din));
      check("cyc_ovf", 32'(O_overflow), 32'(ovf));
      check("cyc_total", 32'(O_drop_total), 32'(total));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [17:0] got [8];
  int          got_n;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic set_ev(input int cmd, input int t, input int st, input int d);
    I_data_wr = 1'b1;
    I_command = 2'(cmd);
    I_time    = 16'(t);
    I_status  = 5'(st);
    I_data    = 8'(d);
  endtask

  task automatic idle();
    I_data_wr = 1'b0;
  endtask

  // Bounded window: record every word written within n cycles
  task automatic collect(input int n);
    got_n = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (O_fifo_wr && got_n < 8) begin
        got[got_n] = O_fifo_din;
        got_n++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; I_arm = 1'b0; I_fifo_full = 1'b0;
    I_data_wr = 1'b0; I_command = '0; I_time = '0; I_data = '0; I_status = '0;
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    tick(); tick();
    check("rst_wr", 32'(O_fifo_wr), 0);
    check("rst_din", 32'(O_fifo_din), 0);
    check("rst_ovf", 32'(O_overflow), 0);
    check("rst_total", 32'(O_drop_total), 0);
    reset_n = 1'b1;
    tick();

    // Single DATA event: one-cycle latency, single pulse
    set_ev(0, 5, 3, 'hA5); tick(); idle();
    check("data_wr", 32'(O_fifo_wr), 1);
    check("data_word", 32'(O_fifo_din), 32'h0A3A5);
    tick();
    check("data_pulse", 32'(O_fifo_wr), 0);

    // TIME and STAT formats
    set_ev(2, 'h1234, 'h1F, 'hFF); tick(); idle();
    check("time_word", 32'(O_fifo_din), 32'h21234);
    tick();
    set_ev(1, 'h0007, 'h1F, 'hFF); tick(); idle();
    check("stat_word", 32'(O_fifo_din), 32'h1FF00);
    tick();

    // Back-to-back events
    for (int i = 0; i < 4; i++) begin
      set_ev(i % 3, i * 3 + 1, i + 4, 16 * i + 7); tick();
    end
    idle(); tick(); tick();

    // Intermittent full without loss: buffering, simultaneous push/pop
    for (int i = 0; i < 12; i++) begin
      I_fifo_full = (i % 3 == 0);
      if (i % 2 == 0) set_ev(0, i, i, 'h40 + i);
      else idle();
      tick();
    end
    idle(); I_fifo_full = 1'b0;
    repeat (5) tick();
    check("no_drop_ovf", 32'(O_overflow), 0);

    // Five events while full: two buffered, three dropped, then marker
    I_fifo_full = 1'b1;
    set_ev(0, 'h10, 1, 'h11);   tick();
    set_ev(2, 'hBEEF, 0, 0);    tick();
    for (int i = 0; i < 3; i++) begin
      set_ev(0, i, 0, i); tick();
    end
    idle(); tick();
    check("ovf_total", 32'(O_drop_total), 3);
    check("ovf_flag", 32'(O_overflow), 1);
    I_fifo_full = 1'b0;
    collect(8);
    check("ovf_nwords", 32'(got_n), 3);
    check("ovf_word0", 32'(got[0]), 32'h00111);
    check("ovf_word1", 32'(got[1]), 32'h2BEEF);
    check("ovf_marker", 32'(got[2]), 32'h30003);
    check("ovf_total_after", 32'(O_drop_total), 3);
    check("ovf_flag_after", 32'(O_overflow), 1);

    // Saturation: 0x10005 drops
    I_fifo_full = 1'b1;
    set_ev(0, 6, 2, 'h33);
    repeat (2 + 'h10005) tick();
    idle(); tick();
    check("sat_total", 32'(O_drop_total), 32'hFFFF);
    I_fifo_full = 1'b0;
    collect(8);
    check("sat_nwords", 32'(got_n), 3);
    check("sat_marker", 32'(got[2]), 32'h3FFFF);

    // Arm edge while dropping with two words buffered (plus an event in the arm cycle)
    I_fifo_full = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_ev(0, i, 1, i); tick();
    end
    I_arm = 1'b1; set_ev(0, 1, 1, 1); tick();
    I_arm = 1'b0; idle();
    check("arm_total", 32'(O_drop_total), 0);
    check("arm_ovf", 32'(O_overflow), 0);
    I_fifo_full = 1'b0;
    collect(6);
    check("arm_nwords", 32'(got_n), 0);
    set_ev(0, 5, 3, 'hA5); tick(); idle();
    check("post_arm_word", 32'(O_fifo_din), 32'h0A3A5);
    tick();

    // Asynchronous reset mid-burst
    set_ev(0, 1, 2, 3); tick();
    check("burst_wr", 32'(O_fifo_wr), 1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_wr", 32'(O_fifo_wr), 0);
    check("async_rst_din", 32'(O_fifo_din), 0);
    idle();
    tick(); tick();
    reset_n = 1'b1;
    set_ev(0, 3, 0, 'h5A); tick(); idle();
    check("post_rst_wr", 32'(O_fifo_wr), 1);
    check("post_rst_word", 32'(O_fifo_din), 32'h0605A);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
